// File: rtl/frame_capture_gate.sv
// Frame capture gate: arms on a request, captures exactly the next complete
// CMOS frame, packs bytes into 16-bit words and streams them to the DDR3 write FIFO.
module frame_capture_gate #(
  parameter int EXP_PIXELS = 1310720,
  parameter int PIX_CNT_W  = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_new_frame,
  input  logic        dest_sd,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic        pix_valid,
  input  logic [7:0]  cmos_data,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        wr_sel,
  output logic        busy,
  output logic        frame_start,
  output logic        frame_done,
  output logic        size_err,
  output logic [15:0] frame_count,
  output logic [7:0]  drop_count,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [PIX_CNT_W-1:0] EXP_CNT = PIX_CNT_W'(EXP_PIXELS);
  localparam logic [PIX_CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic                 vsync_d;
  logic                 rise;
  logic                 fall;
  logic                 byte_ok;
  logic                 phase;
  logic [7:0]           held;
  logic [PIX_CNT_W-1:0] byte_cnt;

  assign rise      = cmos_vsync & ~vsync_d;
  assign fall      = ~cmos_vsync & vsync_d;
  assign byte_ok   = (state == S_CAPTURE) & pix_valid & cmos_href & cmos_vsync;
  assign dbg_state = state;

  // A rise while already in CAPTURE is deliberately not a transition.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (request_new_frame) state_next = S_ARMED;
      S_ARMED:   if (rise)              state_next = S_CAPTURE;
      S_CAPTURE: if (fall)              state_next = S_DONE;
      S_DONE:                           state_next = S_IDLE;
      default:                          state_next = S_IDLE;
    endcase
  end

  // wr_en is a one-cycle valid with no ready: the FIFO must take every word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      vsync_d     <= 1'b0;
      phase       <= 1'b0;
      held        <= 8'h00;
      byte_cnt    <= '0;
      wr_en       <= 1'b0;
      wr_data     <= 16'h0000;
      wr_sel      <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      size_err    <= 1'b0;
      frame_count <= 16'h0000;
      drop_count  <= 8'h00;
    end else begin
      vsync_d     <= cmos_vsync;
      state       <= state_next;
      busy        <= (state_next != S_IDLE);
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      if (request_new_frame) begin
        if (state == S_IDLE) begin
          wr_sel <= dest_sd;
        end else if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end

      if ((state == S_ARMED) && rise) begin
        byte_cnt    <= '0;
        phase       <= 1'b0;
        frame_start <= 1'b1;
      end

      if (byte_ok) begin
        if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + PIX_CNT_W'(1);
        if (!phase) begin
          held <= cmos_data;
        end else begin
          wr_en   <= 1'b1;
          wr_data <= {held, cmos_data};
        end
        phase <= ~phase;
      end

      // byte_ok needs vsync high, so it never coincides with the fall.
      if ((state == S_CAPTURE) && fall) begin
        frame_done  <= 1'b1;
        size_err    <= (byte_cnt != EXP_CNT);
        frame_count <= frame_count + 16'd1;
        if (phase) begin
          wr_en   <= 1'b1;
          wr_data <= {held, 8'h00};
        end
      end
    end
  end

endmodule

// File: doc/frame_capture_gate.md
# frame_capture_gate

Responder to the once-per-second `request_new_frame` pulse: on each accepted request it waits for the next complete CMOS frame and passes exactly that frame, packed into 16-bit words, to the DDR3 write FIFO tagged for the SD or USB path. Requests that arrive while a capture is pending or in progress are dropped and counted. The block never forwards a partial frame. It sits between the CMOS pixel front end and the DDR3 write-side arbiter.

## Interface
- `EXP_PIXELS`, 1310720: expected bytes per frame (1280x1024), used for the size check.
- `PIX_CNT_W`, 22: byte-counter width; must hold `EXP_PIXELS`.
- `clk  in  1`: system clock; all logic on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `request_new_frame  in  1`: 1-cycle request pulse.
- `dest_sd  in  1`: destination select, sampled on request accept (1 = SD, 0 = USB).
- `cmos_vsync  in  1`: high while a frame is active.
- `cmos_href  in  1`: line-valid.
- `pix_valid  in  1`: byte strobe.
- `cmos_data  in  8`: pixel byte.
- `wr_en  out  1`: 1-cycle write strobe to the FIFO.
- `wr_data  out  16`: packed word, first byte in [15:8].
- `wr_sel  out  1`: latched `dest_sd`, held from accept until the next accept.
- `busy  out  1`: high in ARMED, CAPTURE and DONE.
- `frame_start  out  1`: 1-cycle pulse when capture begins.
- `frame_done  out  1`: 1-cycle pulse when capture ends.
- `size_err  out  1`: byte count at the last frame end was not equal to `EXP_PIXELS`.
- `frame_count  out  16`: completed frames; wraps at 65535 -> 0.
- `drop_count  out  8`: dropped requests; saturates at 255.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Edge detection uses registered `vsync_d` (reset value 0):
  - rise = `cmos_vsync & ~vsync_d`
  - fall = `~cmos_vsync & vsync_d`
- States:
  - IDLE: a request latches `dest_sd` into `wr_sel` and moves to ARMED.
  - ARMED: a rise moves to CAPTURE. The byte counter and packing phase clear, and `frame_start` pulses.
  - CAPTURE: a byte is accepted when `pix_valid & cmos_href & cmos_vsync`.
    - Even-phase byte goes to the high holding register.
    - Odd-phase byte completes the word and produces `wr_en`.
    - A fall moves to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- If `cmos_vsync` is already high when a request is accepted, the block ignores the current frame and waits for the next rise.
- A request and a rise in the same IDLE cycle: the block enters ARMED, and that frame is not captured.
- Any request seen outside IDLE (including the DONE cycle) increments `drop_count`, saturating at 255, and does not change `wr_sel`.
- Byte counter saturates at all-ones.
- Odd byte count at frame end: one flush word `{held_byte, 8'h00}` is written.
- `size_err` is updated with `frame_done` and holds until the next `frame_done`. A cleared `size_err` does not depend on the flush.
- A rise seen in CAPTURE without a prior fall is ignored; the block keeps capturing.
- `rst` at any point returns to IDLE with no flush and no `frame_done`. Both counters clear.

## Timing
- Let R be the cycle in which a rise is detected while in ARMED. `frame_start` = 1 and `busy` stays 1 at R+1.
- Bytes are accepted from R+1 onward. Bytes sampled in cycle R are not captured.
- Completing byte sampled at cycle t: `wr_en` = 1 and `wr_data` is valid at t+1, for exactly one cycle.
- Let F be the cycle in which a fall is detected in CAPTURE; bytes in F are ignored because `cmos_vsync` is low. At F+1:
  - `frame_done` = 1
  - flush `wr_en` if the byte count is odd
  - `size_err` and `frame_count` are updated
- `busy` = 0 from F+2. A request at F+2 is accepted.
- Request-to-`busy` latency is 1 cycle.
- No backpressure: the FIFO must absorb one word every 2 cycles in the worst case.

## Test plan
- `EXP_PIXELS`=8. Request with `dest_sd`=1, then a frame of 8 bytes 0x01..0x08. Required response:
  - one `frame_start`
  - `wr_en` x4 with words 0x0102, 0x0304, 0x0506, 0x0708
  - `wr_sel`=1
  - `frame_done` at F+1
  - `size_err`=0, `frame_count`=1
- Request while `cmos_vsync` is already high mid-frame: the current frame produces no `wr_en`. The next frame is captured in full, and `frame_count` rises by 1.
- Frame of 7 bytes 0xA1..0xA7: 4 words, the last being 0xA700 at F+1 together with `frame_done`. `size_err`=1.
- Three requests during CAPTURE plus one in the DONE cycle: `drop_count`=4 and `wr_sel` is unchanged. Then 300 requests while busy: `drop_count` stays at 255.
- `rst` asserted for 1 cycle after 3 bytes in CAPTURE: no `wr_en` for the held byte, no `frame_done`, all outputs 0, state IDLE. The next request and frame capture normally.
- Request coinciding with a rise in IDLE: that frame is skipped, the following frame is captured, and `frame_start` occurs at the second rise + 1.
